// File: rtl/wb_pkg.sv
// Shared widths, register-file constants and helper types for the write-back port arbiter.
package wb_pkg;

  localparam int REG_AW        = 5;
  localparam int DATA_W        = 32;
  localparam int NUM_ARCH_REGS = 2 ** REG_AW;

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer, which advances past each winner.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  // Walk the requesters starting at the pointer; the first valid one wins.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_q) + k) % N);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
        ptr_d    = PW'((int'(idx) + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port among NUM_REQ producers and tracks pending writes per register.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = wb_pkg::DATA_W,
  parameter int REG_AW  = wb_pkg::REG_AW
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*REG_AW-1:0] req_dest,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      stall,
  input  logic                      issue_valid,
  input  logic [REG_AW-1:0]         issue_dest,
  output logic [REG_AW-1:0]         dest_reg,
  output logic [DATA_W-1:0]         value_to_write,
  output logic                      wb_valid,
  output logic [2**REG_AW-1:0]      busy_vec
);

  localparam int NREGS = 2 ** REG_AW;

  // Handshake: producer i transfers at a rising edge where req_valid[i] && req_ready[i];
  // req_ready is a function of req_valid, stall and the pointer only, and a producer
  // holds valid/dest/data steady until it sees that edge.
  logic [NUM_REQ-1:0] gnt;
  logic               arb_en;
  logic               handshake;
  logic [REG_AW-1:0]  sel_dest;
  logic [DATA_W-1:0]  sel_data;
  logic [NREGS-1:0]   busy_d;

  assign arb_en = reset && !stall;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .en    (arb_en),
    .gnt   (gnt)
  );

  assign req_ready = gnt;
  assign handshake = |(gnt & req_valid);

  always_comb begin
    sel_dest = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_dest = sel_dest | req_dest[i*REG_AW +: REG_AW];
        sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Write_Back commits every cycle, so an idle cycle drives R0 <= 0 and R0 writes are zeroed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dest_reg       <= '0;
      value_to_write <= '0;
      wb_valid       <= 1'b0;
    end else if (handshake) begin
      dest_reg       <= sel_dest;
      value_to_write <= (sel_dest == REG_AW'(ZERO_REG)) ? '0 : sel_data;
      wb_valid       <= 1'b1;
    end else begin
      dest_reg       <= '0;
      value_to_write <= '0;
      wb_valid       <= 1'b0;
    end
  end

  // A new issue to the register being committed this edge keeps the bit set.
  always_comb begin
    busy_d = busy_vec;
    for (int r = 1; r < NREGS; r++) begin
      if (wb_valid && dest_reg == REG_AW'(r)) begin
        busy_d[r] = 1'b0;
      end
      if (issue_valid && issue_dest == REG_AW'(r)) begin
        busy_d[r] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vector table, hand sequences and random traffic vs a model.
module tb_wb_port_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2 ** AW;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_dest;
  logic [N*DW-1:0] req_data;
  logic            stall;
  logic            issue_valid;
  logic [AW-1:0]   issue_dest;
  logic [AW-1:0]   dest_reg;
  logic [DW-1:0]   value_to_write;
  logic            wb_valid;
  logic [NR-1:0]   busy_vec;

  logic [AW-1:0] dest_a [N];
  logic [DW-1:0] data_a [N];

  assign req_dest = {dest_a[2], dest_a[1], dest_a[0]};
  assign req_data = {data_a[2], data_a[1], data_a[0]};

  wb_port_arbiter #(.NUM_REQ(N), .DATA_W(DW), .REG_AW(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_dest       (req_dest),
    .req_data       (req_data),
    .stall          (stall),
    .issue_valid    (issue_valid),
    .issue_dest     (issue_dest),
    .dest_reg       (dest_reg),
    .value_to_write (value_to_write),
    .wb_valid       (wb_valid),
    .busy_vec       (busy_vec)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int            m_ptr;
  logic [AW-1:0] m_dest;
  logic [DW-1:0] m_data;
  logic          m_wb;
  logic [NR-1:0] m_busy;

  int n_checks;
  int n_fail;

  logic [N-1:0]  s_ready;
  logic [AW-1:0] s_dest;
  logic          s_wb;

  typedef struct {
    logic [N-1:0]  rv;
    logic          st;
    logic [N-1:0]  exp_ready;
    logic          exp_wb;
    logic [AW-1:0] exp_dest;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (!reset || stall) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_ptr  = 0;
    m_dest = '0;
    m_data = '0;
    m_wb   = 1'b0;
    m_busy = '0;
  endtask

  // One clock: compare against the model at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    int g;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    g = model_grant();
    exp_ready = (g < 0) ? '0 : N'(1 << g);
    s_ready = req_ready;
    s_dest  = dest_reg;
    s_wb    = wb_valid;
    check("model_ready", 64'(req_ready), 64'(exp_ready));
    check("model_dest", 64'(dest_reg), 64'(m_dest));
    check("model_data", 64'(value_to_write), 64'(m_data));
    check("model_wb", 64'(wb_valid), 64'(m_wb));
    check("model_busy", 64'(busy_vec), 64'(m_busy));
    @(posedge clk);
    if (!reset) begin
      model_clear();
    end else begin
      if (m_wb) m_busy[m_dest] = 1'b0;
      if (issue_valid && issue_dest != 0) m_busy[issue_dest] = 1'b1;
      if (g >= 0) begin
        m_dest = dest_a[g];
        m_data = (dest_a[g] == 0) ? '0 : data_a[g];
        m_wb   = 1'b1;
        m_ptr  = (g + 1) % N;
      end else begin
        m_dest = '0;
        m_data = '0;
        m_wb   = 1'b0;
      end
    end
    #1;
  endtask

  logic [NR-1:0] busy_save;

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b0;
    req_valid   = '0;
    stall       = 1'b0;
    issue_valid = 1'b0;
    issue_dest  = '0;
    for (int i = 0; i < N; i++) begin
      dest_a[i] = AW'(i + 1);
      data_a[i] = DW'(32'hA0 + i);
    end
    model_clear();

    vecs[0]  = '{3'b111, 1'b0, 3'b001, 1'b0, 5'd0};
    vecs[1]  = '{3'b111, 1'b0, 3'b010, 1'b1, 5'd1};
    vecs[2]  = '{3'b111, 1'b0, 3'b100, 1'b1, 5'd2};
    vecs[3]  = '{3'b111, 1'b0, 3'b001, 1'b1, 5'd3};
    vecs[4]  = '{3'b111, 1'b0, 3'b010, 1'b1, 5'd1};
    vecs[5]  = '{3'b111, 1'b0, 3'b100, 1'b1, 5'd2};
    vecs[6]  = '{3'b001, 1'b0, 3'b001, 1'b1, 5'd3};
    vecs[7]  = '{3'b110, 1'b1, 3'b000, 1'b1, 5'd1};
    vecs[8]  = '{3'b110, 1'b1, 3'b000, 1'b0, 5'd0};
    vecs[9]  = '{3'b110, 1'b0, 3'b010, 1'b0, 5'd0};
    vecs[10] = '{3'b110, 1'b0, 3'b100, 1'b1, 5'd2};
    vecs[11] = '{3'b000, 1'b0, 3'b000, 1'b1, 5'd3};
    vecs[12] = '{3'b000, 1'b0, 3'b000, 1'b0, 5'd0};

    // Power-on reset
    req_valid = 3'b111;
    cycle();
    cycle();
    check("reset_ready", 64'(req_ready), 64'(0));
    check("reset_wb", 64'(wb_valid), 64'(0));
    reset = 1'b1;

    // Fairness and stall vectors
    for (int v = 0; v < 13; v++) begin
      req_valid = vecs[v].rv;
      stall     = vecs[v].st;
      cycle();
      check($sformatf("vec%0d_ready", v), 64'(s_ready), 64'(vecs[v].exp_ready));
      check($sformatf("vec%0d_wb", v), 64'(s_wb), 64'(vecs[v].exp_wb));
      check($sformatf("vec%0d_dest", v), 64'(s_dest), 64'(vecs[v].exp_dest));
    end
    stall = 1'b0;

    // R0 forcing
    dest_a[2] = '0;
    data_a[2] = 32'hDEADBEEF;
    req_valid = 3'b100;
    cycle();
    req_valid = 3'b000;
    check("r0_dest", 64'(dest_reg), 64'(0));
    check("r0_data", 64'(value_to_write), 64'(0));
    check("r0_wb", 64'(wb_valid), 64'(1));
    cycle();
    dest_a[2] = AW'(3);
    data_a[2] = 32'hA2;

    // Scoreboard set / clear / set-wins
    issue_valid = 1'b1;
    issue_dest  = AW'(5);
    cycle();
    issue_valid = 1'b0;
    check("sb_set", 64'(busy_vec[5]), 64'(1));
    dest_a[1]  = AW'(5);
    req_valid  = 3'b010;
    cycle();
    req_valid  = 3'b000;
    check("sb_wb_dest", 64'(dest_reg), 64'(5));
    check("sb_still_busy", 64'(busy_vec[5]), 64'(1));
    cycle();
    check("sb_clear", 64'(busy_vec[5]), 64'(0));
    issue_valid = 1'b1;
    cycle();
    issue_valid = 1'b0;
    req_valid   = 3'b010;
    cycle();
    req_valid   = 3'b000;
    issue_valid = 1'b1;
    cycle();
    issue_valid = 1'b0;
    check("sb_set_wins", 64'(busy_vec[5]), 64'(1));
    dest_a[1] = AW'(2);

    // Idle drive
    cycle();
    busy_save = busy_vec;
    for (int c = 0; c < 4; c++) begin
      cycle();
      check("idle_wb", 64'(wb_valid), 64'(0));
      check("idle_busy", 64'(busy_vec), 64'(busy_save));
    end

    // Reset mid-stream
    req_valid = 3'b111;
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    model_clear();
    check("midrst_ready", 64'(req_ready), 64'(0));
    check("midrst_wb", 64'(wb_valid), 64'(0));
    check("midrst_dest", 64'(dest_reg), 64'(0));
    check("midrst_busy", 64'(busy_vec), 64'(0));
    cycle();
    reset = 1'b1;
    cycle();
    check("midrst_first_grant", 64'(s_ready), 64'(3'b001));

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      req_valid   = N'($urandom_range(0, 7));
      stall       = ($urandom_range(0, 3) == 0);
      issue_valid = $urandom_range(0, 1) == 1;
      issue_dest  = AW'($urandom_range(0, NR - 1));
      for (int i = 0; i < N; i++) begin
        dest_a[i] = AW'($urandom_range(0, NR - 1));
        data_a[i] = DW'($urandom);
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
